// File: rtl/rv_mul_pkg.sv
// Shared definitions for the pipelined RV32M/RV64M multiplier:
// operation encodings and the op-normalisation helper.
package rv_mul_pkg;

   localparam int MUL_OP_W = 3;

   localparam logic [MUL_OP_W-1:0] MUL_OP_MUL    = 3'd0;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MULH   = 3'd1;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MULHSU = 3'd2;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MULHU  = 3'd3;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MULW   = 3'd4;

   // Fold unused encodings (5-7) onto MUL. MULW only exists on a 64-bit
   // datapath, so it also folds onto MUL when w_legal is low.
   function automatic logic [MUL_OP_W-1:0] mul_op_norm(
      input logic [MUL_OP_W-1:0] op,
      input logic                w_legal
   );
      if (op > MUL_OP_MULW)
         return MUL_OP_MUL;
      if ((op == MUL_OP_MULW) && !w_legal)
         return MUL_OP_MUL;
      return op;
   endfunction

endpackage

// File: rtl/rv_mul_stage.sv
// One register slice of the multiplier pipeline: valid, tag, op and data.
// The slice advances when en is high; clr kills the valid bit and wins
// over a held (stalled) slice. Data registers are not cleared by clr.
module rv_mul_stage
   import rv_mul_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int TAG_W  = 5
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                en,
   input  logic                clr,
   input  logic                valid_d,
   input  logic [TAG_W-1:0]    tag_d,
   input  logic [MUL_OP_W-1:0] op_d,
   input  logic [DATA_W-1:0]   data_d,
   output logic                valid_q,
   output logic [TAG_W-1:0]    tag_q,
   output logic [MUL_OP_W-1:0] op_q,
   output logic [DATA_W-1:0]   data_q
);

   // Valid bit: flush clears regardless of stall, otherwise shift when enabled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= 1'b0;
      end else if (clr) begin
         valid_q <= 1'b0;
      end else if (en) begin
         valid_q <= valid_d;
      end
   end

   // Payload: shifts with the pipeline, held while stalled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tag_q  <= '0;
         op_q   <= MUL_OP_MUL;
         data_q <= '0;
      end else if (en) begin
         tag_q  <= tag_d;
         op_q   <= op_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/rv_mul_pipe.sv
// Pipelined integer multiplier for the RV32M/RV64M execute stage.
// The full-width product is formed in front of the first slice and carried
// down a rigid STAGES-deep shift register (synthesis may retime the
// multiplier across the slices); the result half is selected at the end.
module rv_mul_pipe
   import rv_mul_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int STAGES = 3,
   parameter int TAG_W  = 5
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                mul_valid_i,
   output logic                mul_ready_o,
   input  logic [2:0]          mul_op_i,
   input  logic [XLEN-1:0]     mul_op1_i,
   input  logic [XLEN-1:0]     mul_op2_i,
   input  logic [TAG_W-1:0]    mul_tag_i,
   input  logic                mul_flush_i,
   output logic                mul_valid_o,
   input  logic                mul_ready_i,
   output logic [XLEN-1:0]     mul_result_o,
   output logic [TAG_W-1:0]    mul_tag_o,
   output logic                mul_busy_o
);

   localparam int PROD_W = 2 * XLEN;

   logic                        stall;
   logic                        accept;
   logic [MUL_OP_W-1:0]         op_norm;
   logic                        op1_signed;
   logic                        op2_signed;
   logic [XLEN-1:0]             op1_src;
   logic [XLEN-1:0]             op2_src;
   logic [PROD_W-1:0]           op1_wide;
   logic [PROD_W-1:0]           op2_wide;
   logic [PROD_W-1:0]           prod;

   // Index 0 is the slice input; index gi+1 is the output of slice gi.
   logic [STAGES:0]                     stg_valid;
   logic [STAGES:0][TAG_W-1:0]          stg_tag;
   logic [STAGES:0][MUL_OP_W-1:0]       stg_op;
   logic [STAGES:0][PROD_W-1:0]         stg_data;

   logic [PROD_W-1:0]           last_data;
   logic [MUL_OP_W-1:0]         last_op;

   assign stall       = mul_valid_o & ~mul_ready_i;
   assign mul_ready_o = ~stall & ~mul_flush_i;
   assign accept      = mul_valid_i & mul_ready_o;

   // Operand decode: signedness per op, MULW narrows both operands to their
   // sign-extended low words so the low 32 product bits are the MULW result.
   always_comb begin
      op_norm    = mul_op_norm(mul_op_i, XLEN == 64);
      op1_signed = (op_norm != MUL_OP_MULHU);
      op2_signed = (op_norm == MUL_OP_MUL) || (op_norm == MUL_OP_MULH) ||
                   (op_norm == MUL_OP_MULW);
      op1_src    = mul_op1_i;
      op2_src    = mul_op2_i;
      if (op_norm == MUL_OP_MULW) begin
         op1_src = XLEN'($signed(mul_op1_i[31:0]));
         op2_src = XLEN'($signed(mul_op2_i[31:0]));
      end
      // Extending straight to 2*XLEN gives the same low 2*XLEN bits as the
      // (XLEN+1)x(XLEN+1) signed product, without unused top bits.
      op1_wide = {{XLEN{op1_signed & op1_src[XLEN-1]}}, op1_src};
      op2_wide = {{XLEN{op2_signed & op2_src[XLEN-1]}}, op2_src};
   end

   assign prod = op1_wide * op2_wide;

   assign stg_valid[0] = accept;
   assign stg_tag[0]   = mul_tag_i;
   assign stg_op[0]    = op_norm;
   assign stg_data[0]  = prod;

   // Rigid shift register of register slices, all gated by the same stall.
   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         rv_mul_stage #(
            .DATA_W (PROD_W),
            .TAG_W  (TAG_W)
         ) u_stage (
            .clk     (clk),
            .rstn    (rstn),
            .en      (~stall),
            .clr     (mul_flush_i),
            .valid_d (stg_valid[gi]),
            .tag_d   (stg_tag[gi]),
            .op_d    (stg_op[gi]),
            .data_d  (stg_data[gi]),
            .valid_q (stg_valid[gi+1]),
            .tag_q   (stg_tag[gi+1]),
            .op_q    (stg_op[gi+1]),
            .data_q  (stg_data[gi+1])
         );
      end
   endgenerate

   assign last_data   = stg_data[STAGES];
   assign last_op     = stg_op[STAGES];
   assign mul_valid_o = stg_valid[STAGES];
   assign mul_tag_o   = stg_tag[STAGES];
   assign mul_busy_o  = |stg_valid[STAGES:1];

   // Result select from the last slice: low half, high half or sign-extended word.
   always_comb begin
      mul_result_o = last_data[XLEN-1:0];
      case (last_op)
         MUL_OP_MULH,
         MUL_OP_MULHSU,
         MUL_OP_MULHU:  mul_result_o = last_data[PROD_W-1:XLEN];
         MUL_OP_MULW:   mul_result_o = XLEN'($signed(last_data[31:0]));
         default:       mul_result_o = last_data[XLEN-1:0];
      endcase
   end

endmodule

// File: tb/tb_rv_mul_pipe.sv
// Self-checking bench for rv_mul_pipe: directed known-answer vectors,
// latency, backpressure, flush, async reset and a randomised run, all
// checked through an in-order scoreboard of expected (result, tag) pairs.
module tb_rv_mul_pipe;
   import rv_mul_pkg::*;

   localparam int XLEN   = 64;
   localparam int STAGES = 3;
   localparam int TAG_W  = 5;

   typedef struct {
      logic [XLEN-1:0]  res;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic              clk;
   logic              rstn;
   logic              mul_valid_i;
   logic              mul_ready_o;
   logic [2:0]        mul_op_i;
   logic [XLEN-1:0]   mul_op1_i;
   logic [XLEN-1:0]   mul_op2_i;
   logic [TAG_W-1:0]  mul_tag_i;
   logic              mul_flush_i;
   logic              mul_valid_o;
   logic              mul_ready_i;
   logic [XLEN-1:0]   mul_result_o;
   logic [TAG_W-1:0]  mul_tag_o;
   logic              mul_busy_o;

   exp_t sb_q[$];
   int   total     = 0;
   int   bad       = 0;
   int   delivered = 0;
   bit   rand_ready_en = 0;

   rv_mul_pipe #(
      .XLEN   (XLEN),
      .STAGES (STAGES),
      .TAG_W  (TAG_W)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .mul_valid_i  (mul_valid_i),
      .mul_ready_o  (mul_ready_o),
      .mul_op_i     (mul_op_i),
      .mul_op1_i    (mul_op1_i),
      .mul_op2_i    (mul_op2_i),
      .mul_tag_i    (mul_tag_i),
      .mul_flush_i  (mul_flush_i),
      .mul_valid_o  (mul_valid_o),
      .mul_ready_i  (mul_ready_i),
      .mul_result_o (mul_result_o),
      .mul_tag_o    (mul_tag_o),
      .mul_busy_o   (mul_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reference written in 128-bit unsigned arithmetic.
   function automatic logic [63:0] ref_mul(input logic [2:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
      logic [127:0] p;
      logic [31:0]  w;
      case (op)
         3'd1: begin
            p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
            return p[127:64];
         end
         3'd2: begin
            p = {{64{a[63]}}, a} * {64'd0, b};
            return p[127:64];
         end
         3'd3: begin
            p = {64'd0, a} * {64'd0, b};
            return p[127:64];
         end
         3'd4: begin
            w = a[31:0] * b[31:0];
            return {{32{w[31]}}, w};
         end
         default: return a * b;
      endcase
   endfunction

   function automatic logic [63:0] pick_operand();
      logic [63:0] v;
      case ($urandom_range(0, 7))
         0: v = 64'd0;
         1: v = 64'd1;
         2: v = 64'hFFFF_FFFF_FFFF_FFFF;
         3: v = 64'h8000_0000_0000_0000;
         4: v = 64'h7FFF_FFFF_FFFF_FFFF;
         5: v = {32'($urandom), 32'h8000_0000};
         default: v = {32'($urandom), 32'($urandom)};
      endcase
      return v;
   endfunction

   // Scoreboard: every output handshake (valid & ready, stable at the
   // falling edge) is matched against the oldest expected entry.
   always @(negedge clk) begin
      if (rstn && mul_valid_o && mul_ready_i) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_result: got tag=%0d data=%h, required no result",
                     mul_tag_o, mul_result_o);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            delivered++;
            if ((mul_result_o !== e.res) || (mul_tag_o !== e.tag)) begin
               bad++;
               $display("FAIL result_check: got tag=%0d data=%h, required tag=%0d data=%h",
                        mul_tag_o, mul_result_o, e.tag, e.res);
            end else begin
               $display("result tag=%0d data=%h", mul_tag_o, mul_result_o);
            end
         end
      end
   end

   // Random downstream backpressure for the randomised run.
   always @(posedge clk) begin
      if (rand_ready_en) begin
         #1 mul_ready_i = ($urandom_range(0, 3) != 0);
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tag, input logic [63:0] exp_res);
      int   guard = 0;
      exp_t e;
      mul_valid_i = 1'b1;
      mul_op_i    = op;
      mul_op1_i   = a;
      mul_op2_i   = b;
      mul_tag_i   = tag;
      @(negedge clk);
      while (!mul_ready_o && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!mul_ready_o) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: ready_o=%b after %0d cycles, required 1", mul_ready_o, guard);
      end else begin
         e.res = exp_res;
         e.tag = tag;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      mul_valid_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      mul_ready_i = 1'b1;
      while (sb_q.size() != 0 && guard < 300) begin
         @(posedge clk);
         #1;
         guard++;
      end
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb_q.size());
      end
   endtask

   task automatic test_reset();
      rstn        = 1'b0;
      mul_valid_i = 1'b0;
      mul_op_i    = 3'd0;
      mul_op1_i   = '0;
      mul_op2_i   = '0;
      mul_tag_i   = '0;
      mul_flush_i = 1'b0;
      mul_ready_i = 1'b1;
      #23;
      total++;
      if ({mul_valid_o, mul_busy_o, mul_ready_o} !== 3'b001) begin
         bad++;
         $display("FAIL reset_ctrl: valid/busy/ready=%b, required 001",
                  {mul_valid_o, mul_busy_o, mul_ready_o});
      end
      total++;
      if ((mul_result_o !== 64'd0) || (mul_tag_o !== 5'd0)) begin
         bad++;
         $display("FAIL reset_data: result=%h tag=%0d, required 0 and 0", mul_result_o, mul_tag_o);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_latency();
      int lat = 1;
      issue(MUL_OP_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB);
      while (!mul_valid_o && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      total++;
      if (lat != STAGES) begin
         bad++;
         $display("FAIL latency: got %0d cycles, required %0d", lat, STAGES);
      end
      drain("latency");
   endtask

   task automatic test_known_vectors();
      issue(MUL_OP_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd2, 64'h4000_0000_0000_0000);
      issue(MUL_OP_MULHU,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd3, 64'h4000_0000_0000_0000);
      issue(MUL_OP_MULHSU, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4, 64'hC000_0000_0000_0000);
      issue(MUL_OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE);
      issue(MUL_OP_MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'h0000_0000_0000_0001);
      issue(MUL_OP_MULW,   64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE);
      issue(3'd6,          64'hFFFF_FFFF_FFFF_FFFD, 64'd7,                   5'd8, 64'hFFFF_FFFF_FFFF_FFEB);
      drain("known");
   endtask

   task automatic test_back_to_back();
      int base = delivered;
      fork
         begin
            for (int t = 0; t < 8; t++) begin
               logic [63:0] a;
               a = 64'h0000_0001_0000_0000 + 64'(t);
               issue(MUL_OP_MUL, a, 64'd3, 5'(t), a * 64'd3);
            end
         end
         begin
            int guard = 0;
            while (delivered < base + 2 && guard < 100) begin
               @(posedge clk);
               #1;
               guard++;
            end
            mul_ready_i = 1'b0;
            repeat (4) begin
               @(negedge clk);
               total++;
               if ((mul_ready_o !== 1'b0) || (mul_valid_o !== 1'b1)) begin
                  bad++;
                  $display("FAIL stall_ready: ready_o=%b valid_o=%b, required 0 and 1",
                           mul_ready_o, mul_valid_o);
               end
               @(posedge clk);
               #1;
            end
            mul_ready_i = 1'b1;
         end
      join
      drain("b2b");
      total++;
      if (delivered != base + 8) begin
         bad++;
         $display("FAIL b2b_count: delivered %0d, required 8", delivered - base);
      end
   endtask

   task automatic test_flush();
      mul_ready_i = 1'b0;
      issue(MUL_OP_MUL, 64'd11, 64'd13, 5'd20, 64'd143);
      issue(MUL_OP_MUL, 64'd12, 64'd13, 5'd21, 64'd156);
      issue(MUL_OP_MUL, 64'd14, 64'd13, 5'd22, 64'd182);
      total++;
      if ((mul_busy_o !== 1'b1) || (mul_valid_o !== 1'b1)) begin
         bad++;
         $display("FAIL flush_pre: busy=%b valid_o=%b, required 1 and 1", mul_busy_o, mul_valid_o);
      end
      mul_flush_i = 1'b1;
      mul_valid_i = 1'b1;
      mul_op_i    = MUL_OP_MUL;
      mul_tag_i   = 5'd23;
      @(negedge clk);
      total++;
      if (mul_ready_o !== 1'b0) begin
         bad++;
         $display("FAIL flush_ready: ready_o=%b during flush, required 0", mul_ready_o);
      end
      @(posedge clk);
      #1;
      mul_flush_i = 1'b0;
      mul_valid_i = 1'b0;
      sb_q.delete();
      total++;
      if ((mul_busy_o !== 1'b0) || (mul_valid_o !== 1'b0)) begin
         bad++;
         $display("FAIL flush_post: busy=%b valid_o=%b, required 0 and 0", mul_busy_o, mul_valid_o);
      end
      mul_ready_i = 1'b1;
      repeat (STAGES + 3) begin
         @(negedge clk);
         total++;
         if (mul_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_leak: valid_o=%b tag=%0d, required valid_o 0", mul_valid_o, mul_tag_o);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      rand_ready_en = 1;
      for (int i = 0; i < 1024; i++) begin
         logic [2:0]  op;
         logic [63:0] a;
         logic [63:0] b;
         op = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         issue(op, a, b, 5'($urandom), ref_mul(op, a, b));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_ready_en = 0;
      @(posedge clk);
      #2;
      drain("random");
   endtask

   task automatic test_async_reset();
      mul_ready_i = 1'b1;
      issue(MUL_OP_MUL, 64'd5, 64'd6, 5'd9, 64'd30);
      issue(MUL_OP_MUL, 64'd7, 64'd6, 5'd10, 64'd42);
      #2;
      rstn = 1'b0;
      #1;
      sb_q.delete();
      total++;
      if ({mul_valid_o, mul_busy_o, mul_ready_o} !== 3'b001) begin
         bad++;
         $display("FAIL async_reset: valid/busy/ready=%b, required 001",
                  {mul_valid_o, mul_busy_o, mul_ready_o});
      end
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_known_vectors();
      test_back_to_back();
      test_flush();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
